// File: rtl/mmio_confreg_resp_pkg.sv
// Shared definitions for the memory-mapped configuration register responder:
// register offsets, UART transmitter state encoding and a byte-lane merge helper.
package mmio_confreg_resp_pkg;

    localparam logic [15:0] CONFREG_LED       = 16'h0000;
    localparam logic [15:0] CONFREG_SW        = 16'h0004;
    localparam logic [15:0] CONFREG_TIMER     = 16'h0008;
    localparam logic [15:0] CONFREG_SCRATCH   = 16'h000C;
    localparam logic [15:0] CONFREG_UART_DATA = 16'h0010;
    localparam logic [15:0] CONFREG_UART_STAT = 16'h0014;

    typedef enum logic [1:0] {
        UART_IDLE,
        UART_START,
        UART_DATA,
        UART_STOP
    } uart_state_e;

    // Replace each byte lane of old_val whose enable bit is set with new_val.
    function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  be);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) res[8*i +: 8] = new_val[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/mmio_confreg_resp_uart_tx_fsm.sv
// 8N1 UART transmitter: start bit, eight data bits LSB first, stop bit,
// each held for BAUD_DIV clock cycles.
module uart_tx_fsm
    import mmio_confreg_resp_pkg::*;
#(
    parameter int unsigned BAUD_DIV = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data,
    output logic       txd,
    output logic       busy
);

    localparam int unsigned CW = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);

    uart_state_e   state;
    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          bit_end;

    assign bit_end = (baud_cnt == BAUD_LAST);
    assign busy    = (state != UART_IDLE);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= UART_IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            txd      <= 1'b1;
        end else begin
            baud_cnt <= (state == UART_IDLE || bit_end) ? '0 : baud_cnt + 1'b1;
            case (state)
                UART_IDLE: begin
                    if (start) begin
                        state <= UART_START;
                        shreg <= data;
                        txd   <= 1'b0;
                    end
                end
                UART_START: begin
                    if (bit_end) begin
                        state   <= UART_DATA;
                        bit_idx <= '0;
                        txd     <= shreg[0];
                    end
                end
                UART_DATA: begin
                    if (bit_end) begin
                        if (bit_idx == 3'd7) begin
                            state <= UART_STOP;
                            txd   <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            txd     <= shreg[bit_idx + 3'd1];
                        end
                    end
                end
                UART_STOP: begin
                    if (bit_end) state <= UART_IDLE;
                end
                default: state <= UART_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/mmio_confreg_resp.sv
// Peripheral-window responder on the data-side SRAM-like port: LED, switches,
// free-running timer, scratch and UART TX registers with one-cycle read latency.
module mmio_confreg_resp
    import mmio_confreg_resp_pkg::*;
#(
    parameter logic [15:0] BASE_HI  = 16'hBFAF,
    parameter int unsigned BAUD_DIV = 16,
    parameter int unsigned SW_SYNC  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [3:0]  wen,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic [15:0] switch_i,
    output logic [15:0] led_o,
    output logic        uart_txd,
    output logic        uart_busy
);

    logic                      hit, rd_req, wr_req;
    logic [15:0]               offset;
    logic                      unused_addr_bits;
    logic [SW_SYNC-1:0][15:0]  sw_sync;
    logic [31:0]               timer, scratch, rd_val;
    logic                      overrun;
    logic                      uart_wr, uart_start, ovr_set, ovr_clr;

    assign hit              = en && (addr[31:16] == BASE_HI);
    assign rd_req           = hit && (wen == 4'b0000);
    assign wr_req           = hit && (wen != 4'b0000);
    assign offset           = {addr[15:2], 2'b00};
    assign unused_addr_bits = ^addr[1:0];

    assign uart_wr    = wr_req && (offset == CONFREG_UART_DATA) && wen[0];
    assign uart_start = uart_wr && !uart_busy;
    assign ovr_set    = uart_wr && uart_busy;
    assign ovr_clr    = wr_req && (offset == CONFREG_UART_STAT) && wen[0] && wdata[1];

    // NOTE: every output of a combinational block gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        rd_val = '0;
        case (offset)
            CONFREG_LED:       rd_val = {16'h0000, led_o};
            CONFREG_SW:        rd_val = {16'h0000, sw_sync[SW_SYNC-1]};
            CONFREG_TIMER:     rd_val = timer;
            CONFREG_SCRATCH:   rd_val = scratch;
            CONFREG_UART_STAT: rd_val = {30'h0, overrun, uart_busy};
            default:           rd_val = '0;
        endcase
    end

    // NOTE: the switch synchroniser is a handful of flops, not a RAM, so it is
    // cleared on reset like any other control register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sw_sync <= '0;
            rdata   <= '0;
            led_o   <= '0;
            timer   <= '0;
            scratch <= '0;
            overrun <= 1'b0;
        end else begin
            sw_sync <= {sw_sync[SW_SYNC-2:0], switch_i};
            // Reads see pre-edge contents; non-read cycles return zero.
            rdata   <= rd_req ? rd_val : '0;
            if (wr_req && offset == CONFREG_LED) begin
                if (wen[0]) led_o[7:0]  <= wdata[7:0];
                if (wen[1]) led_o[15:8] <= wdata[15:8];
            end
            // Written timer bytes load directly; the rest keep counting.
            timer <= byte_merge(timer + 32'd1, wdata,
                                (wr_req && offset == CONFREG_TIMER) ? wen : 4'b0000);
            if (wr_req && offset == CONFREG_SCRATCH)
                scratch <= byte_merge(scratch, wdata, wen);
            if (ovr_set)
                overrun <= 1'b1;
            else if (ovr_clr)
                overrun <= 1'b0;
        end
    end

    uart_tx_fsm #(
        .BAUD_DIV (BAUD_DIV)
    ) u_uart_tx (
        .clk   (clk),
        .rst   (rst),
        .start (uart_start),
        .data  (wdata[7:0]),
        .txd   (uart_txd),
        .busy  (uart_busy)
    );

endmodule
